// File: rtl/forwarding_unit_pkg.sv
// Shared types for the forwarding and hazard control logic.
// Combinational helpers only; no state lives here.
// No handshakes; consumers decide stall/flush policy.
package forwarding_unit_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    // Which stage an ID-stage source operand must be valid in.
    typedef enum logic [1:0] {
        NoType  = 2'd0,
        Type1   = 2'd1,
        Type2   = 2'd2,
        Type1_3 = 2'd3
    } forwarding_type_t;

    typedef enum logic [1:0] {
        Run       = 2'd0,
        MemWait   = 2'd1,
        TrapFlush = 2'd2
    } hazard_state_t;

    // A producer matches a source only if it writes, and x0 never creates a dependency.
    function automatic logic operand_match(
        input logic                  reg_we,
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] rd
    );
        return reg_we && (rs != '0) && (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_stall_counter.sv
// Saturating event counter for stall performance monitoring.
// Count visible one cycle after the enabled edge.
// No backpressure; sticks at all-ones instead of wrapping.
module hazard_stall_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Increment on enable unless already saturated.
    always_comb begin
        count_d = count_q;
        if (en && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline stall/flush controller: hazard bubbles, memory freezes, trap drain.
// Stall/flush outputs combinational from state+inputs; state/counters update next edge.
// Freezes IF..MEM while data memory is unacknowledged; holds IF while a fetch is pending.
module hazard_control_unit
    import forwarding_unit_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned COUNT_WIDTH  = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [REG_ADDR_W-1:0]  id_rs1,
    input  logic [REG_ADDR_W-1:0]  id_rs2,
    input  forwarding_type_t       id_rs1_type,
    input  forwarding_type_t       id_rs2_type,
    input  logic                   ex_reg_we,
    input  logic                   ex_mem_rd,
    input  logic [REG_ADDR_W-1:0]  ex_rd,
    input  logic                   mem_reg_we,
    input  logic                   mem_mem_rd,
    input  logic [REG_ADDR_W-1:0]  mem_rd,
    input  logic                   id_jump,
    input  logic                   fetch_req,
    input  logic                   fetch_ack,
    input  logic                   dmem_req,
    input  logic                   dmem_ack,
    input  logic                   trap_req,
    output logic                   stall_if,
    output logic                   stall_id,
    output logic                   stall_ex,
    output logic                   stall_mem,
    output logic                   flush_id,
    output logic                   flush_ex,
    output logic                   flush_mem,
    output logic                   flush_wb,
    output logic                   trap_busy,
    output logic [COUNT_WIDTH-1:0] hazard_stall_count,
    output logic [COUNT_WIDTH-1:0] mem_stall_count
);

    // Drain counter loads DRAIN_CYCLES-1 so the count of TrapFlush cycles equals DRAIN_CYCLES.
    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

    hazard_state_t state_q;
    hazard_state_t state_d;
    logic [3:0]    drain_q;
    logic [3:0]    drain_d;

    logic rs1_ex_match;
    logic rs2_ex_match;
    logic rs1_mem_match;
    logic rs2_mem_match;
    logic rs1_used;
    logic rs2_used;
    logic rs1_need_id;
    logic rs2_need_id;
    logic hz;
    logic hz_bubble;

    assign rs1_ex_match  = operand_match(ex_reg_we, id_rs1, ex_rd);
    assign rs2_ex_match  = operand_match(ex_reg_we, id_rs2, ex_rd);
    assign rs1_mem_match = operand_match(mem_reg_we, id_rs1, mem_rd);
    assign rs2_mem_match = operand_match(mem_reg_we, id_rs2, mem_rd);
    assign rs1_used      = (id_rs1_type != NoType);
    assign rs2_used      = (id_rs2_type != NoType);
    assign rs1_need_id   = (id_rs1_type == Type1) || (id_rs1_type == Type1_3);
    assign rs2_need_id   = (id_rs2_type == Type1) || (id_rs2_type == Type1_3);

    // Dependencies forwarding cannot cover: any use of an EX load, an ID-stage use of
    // an EX ALU result, or an ID-stage use of a MEM load.
    always_comb begin
        hz = 1'b0;
        if (ex_mem_rd && ((rs1_ex_match && rs1_used) || (rs2_ex_match && rs2_used))) begin
            hz = 1'b1;
        end
        if (!ex_mem_rd && ((rs1_ex_match && rs1_need_id) || (rs2_ex_match && rs2_need_id))) begin
            hz = 1'b1;
        end
        if (mem_mem_rd && ((rs1_mem_match && rs1_need_id) || (rs2_mem_match && rs2_need_id))) begin
            hz = 1'b1;
        end
    end

    // Prioritised stall/flush decode and next-state; everything forced low in reset.
    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        flush_mem = 1'b0;
        flush_wb  = 1'b0;
        trap_busy = 1'b0;
        hz_bubble = 1'b0;
        if (reset_n) begin
            unique case (state_q)
                Run: begin
                    if (trap_req) begin
                        stall_if  = 1'b1;
                        flush_id  = 1'b1;
                        flush_ex  = 1'b1;
                        flush_mem = 1'b1;
                        state_d   = TrapFlush;
                        drain_d   = DRAIN_INIT;
                    end else if (dmem_req && !dmem_ack) begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        stall_ex  = 1'b1;
                        stall_mem = 1'b1;
                        flush_wb  = 1'b1;
                        state_d   = MemWait;
                    end else if (hz) begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        flush_ex  = 1'b1;
                        hz_bubble = 1'b1;
                    end else if (fetch_req && !fetch_ack) begin
                        stall_if  = 1'b1;
                        flush_id  = 1'b1;
                    end else if (id_jump) begin
                        flush_id  = 1'b1;
                    end
                end
                MemWait: begin
                    // Traps wait here; MEM holds trap_req until we are back in Run.
                    if (!dmem_ack) begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        stall_ex  = 1'b1;
                        stall_mem = 1'b1;
                        flush_wb  = 1'b1;
                    end else begin
                        state_d   = Run;
                    end
                end
                TrapFlush: begin
                    trap_busy = 1'b1;
                    stall_if  = 1'b1;
                    flush_id  = 1'b1;
                    flush_ex  = 1'b1;
                    flush_mem = 1'b1;
                    if (drain_q == 4'd0) begin
                        state_d = Run;
                    end else begin
                        drain_d = drain_q - 4'd1;
                    end
                end
                default: begin
                    state_d = Run;
                end
            endcase
        end
    end

    // Controller state and trap drain counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= Run;
            drain_q <= 4'd0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    hazard_stall_counter #(
        .WIDTH (COUNT_WIDTH)
    ) u_hazard_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (hz_bubble),
        .count   (hazard_stall_count)
    );

    hazard_stall_counter #(
        .WIDTH (COUNT_WIDTH)
    ) u_mem_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (stall_mem),
        .count   (mem_stall_count)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: directed plan steps then random traffic,
// against a stage-timing reference model; two DUTs (default and DRAIN=1 / 3-bit counters).
module tb_hazard_control_unit;
    import forwarding_unit_pkg::*;

    logic clock;
    logic reset_n;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
    forwarding_type_t id_rs1_type, id_rs2_type;
    logic ex_reg_we, ex_mem_rd, mem_reg_we, mem_mem_rd;
    logic id_jump, fetch_req, fetch_ack, dmem_req, dmem_ack, trap_req;

    logic s_if0, s_id0, s_ex0, s_mem0, f_id0, f_ex0, f_mem0, f_wb0, tb0;
    logic s_if1, s_id1, s_ex1, s_mem1, f_id1, f_ex1, f_mem1, f_wb1, tb1;
    logic [31:0] hc0, mc0;
    logic [2:0]  hc1, mc1;
    logic [8:0]  o0, o1;

    assign o0 = {s_if0, s_id0, s_ex0, s_mem0, f_id0, f_ex0, f_mem0, f_wb0, tb0};
    assign o1 = {s_if1, s_id1, s_ex1, s_mem1, f_id1, f_ex1, f_mem1, f_wb1, tb1};

    hazard_control_unit #(.DRAIN_CYCLES(2), .COUNT_WIDTH(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_type(id_rs1_type), .id_rs2_type(id_rs2_type),
        .ex_reg_we(ex_reg_we), .ex_mem_rd(ex_mem_rd), .ex_rd(ex_rd),
        .mem_reg_we(mem_reg_we), .mem_mem_rd(mem_mem_rd), .mem_rd(mem_rd),
        .id_jump(id_jump), .fetch_req(fetch_req), .fetch_ack(fetch_ack),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack), .trap_req(trap_req),
        .stall_if(s_if0), .stall_id(s_id0), .stall_ex(s_ex0), .stall_mem(s_mem0),
        .flush_id(f_id0), .flush_ex(f_ex0), .flush_mem(f_mem0), .flush_wb(f_wb0),
        .trap_busy(tb0), .hazard_stall_count(hc0), .mem_stall_count(mc0)
    );

    hazard_control_unit #(.DRAIN_CYCLES(1), .COUNT_WIDTH(3)) dut_s (
        .clock(clock), .reset_n(reset_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_type(id_rs1_type), .id_rs2_type(id_rs2_type),
        .ex_reg_we(ex_reg_we), .ex_mem_rd(ex_mem_rd), .ex_rd(ex_rd),
        .mem_reg_we(mem_reg_we), .mem_mem_rd(mem_mem_rd), .mem_rd(mem_rd),
        .id_jump(id_jump), .fetch_req(fetch_req), .fetch_ack(fetch_ack),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack), .trap_req(trap_req),
        .stall_if(s_if1), .stall_id(s_id1), .stall_ex(s_ex1), .stall_mem(s_mem1),
        .flush_id(f_id1), .flush_ex(f_ex1), .flush_mem(f_mem1), .flush_wb(f_wb1),
        .trap_busy(tb1), .hazard_stall_count(hc1), .mem_stall_count(mc1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state per DUT: index 0 = dut, 1 = dut_s.
    int              drain_cfg [2] = '{2, 1};
    longint unsigned cnt_max   [2] = '{64'hFFFF_FFFF, 64'd7};
    bit              m_wait    [2];
    int              m_trap_left [2];   // TrapFlush cycles still to come
    longint unsigned m_hc [2];
    longint unsigned m_mc [2];

    // An operand must stall if the producer's result appears no earlier than the
    // pipeline stage in which the consumer needs it (stage numbers IF=0..WB=4).
    function automatic bit operand_blocked(input logic [4:0] rs, input forwarding_type_t t);
        int need;
        int ready;
        bit blk;
        blk = 0;
        if (t == NoType || rs == 5'd0) return 0;
        need = (t == Type2) ? 2 : 1;
        if (ex_reg_we && ex_rd == rs) begin
            ready = ex_mem_rd ? 3 : 2;
            if (ready >= 1 + need) blk = 1;
        end
        if (mem_reg_we && mem_rd == rs) begin
            ready = mem_mem_rd ? 3 : 2;
            if (ready >= 2 + need) blk = 1;
        end
        return blk;
    endfunction

    // Expected {stall_if,stall_id,stall_ex,stall_mem,flush_id,flush_ex,flush_mem,flush_wb,trap_busy}.
    function automatic logic [8:0] model_out(input int k, output bit bubble);
        bubble = 0;
        if (!reset_n) return 9'b0;
        if (m_trap_left[k] > 0) return 9'b1000_1110_1;
        if (m_wait[k]) return dmem_ack ? 9'b0 : 9'b1111_0001_0;
        if (trap_req) return 9'b1000_1110_0;
        if (dmem_req && !dmem_ack) return 9'b1111_0001_0;
        if (operand_blocked(id_rs1, id_rs1_type) || operand_blocked(id_rs2, id_rs2_type)) begin
            bubble = 1;
            return 9'b1100_0100_0;
        end
        if (fetch_req && !fetch_ack) return 9'b1000_1000_0;
        if (id_jump) return 9'b0000_1000_0;
        return 9'b0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_wait[k] = 0; m_trap_left[k] = 0; m_hc[k] = 0; m_mc[k] = 0;
        end
    endtask

    task automatic model_advance();
        logic [8:0] e;
        bit bub;
        for (int k = 0; k < 2; k++) begin
            e = model_out(k, bub);
            if (bub && m_hc[k] < cnt_max[k]) m_hc[k]++;
            if (e[5] && m_mc[k] < cnt_max[k]) m_mc[k]++;
            if (m_trap_left[k] > 0) m_trap_left[k]--;
            else if (m_wait[k]) begin
                if (dmem_ack) m_wait[k] = 0;
            end else if (trap_req) m_trap_left[k] = drain_cfg[k];
            else if (dmem_req && !dmem_ack) m_wait[k] = 1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are already driven (just after a negedge); compare, then take the edge.
    task automatic step(input string tag);
        logic [8:0] e0, e1;
        bit b;
        #2;
        if (!reset_n) model_reset();
        e0 = model_out(0, b);
        e1 = model_out(1, b);
        check({tag, ":out0"}, 64'(o0), 64'(e0));
        check({tag, ":hcnt0"}, 64'(hc0), m_hc[0]);
        check({tag, ":mcnt0"}, 64'(mc0), m_mc[0]);
        check({tag, ":out1"}, 64'(o1), 64'(e1));
        check({tag, ":hcnt1"}, 64'(hc1), m_hc[1]);
        check({tag, ":mcnt1"}, 64'(mc1), m_mc[1]);
        @(posedge clock);
        if (reset_n) model_advance();
        @(negedge clock);
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_rs1_type = NoType; id_rs2_type = NoType;
        ex_reg_we = 0; ex_mem_rd = 0; ex_rd = 0;
        mem_reg_we = 0; mem_mem_rd = 0; mem_rd = 0;
        id_jump = 0; fetch_req = 0; fetch_ack = 0;
        dmem_req = 0; dmem_ack = 0; trap_req = 0;
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        model_reset();
        step("reset");
        reset_n = 1'b1;
        step("idle");

        // Load in EX feeding an EX-stage operand: one bubble.
        ex_reg_we = 1; ex_mem_rd = 1; ex_rd = 5; id_rs1 = 5; id_rs1_type = Type2;
        step("loaduse");
        check("loaduse_cnt", 64'(hc0), 64'd1);
        idle();
        step("loaduse_after");

        // Load feeding a branch operand: bubble from EX, then again from MEM.
        ex_reg_we = 1; ex_mem_rd = 1; ex_rd = 7; id_rs2 = 7; id_rs2_type = Type1;
        step("ldbr_ex");
        ex_reg_we = 0; ex_mem_rd = 0; ex_rd = 0;
        mem_reg_we = 1; mem_mem_rd = 1; mem_rd = 7;
        step("ldbr_mem");
        check("ldbr_cnt", 64'(hc0), 64'd3);
        idle();

        // x0 never creates a dependency.
        ex_reg_we = 1; ex_mem_rd = 1; ex_rd = 0; id_rs1 = 0; id_rs1_type = Type1;
        step("x0");
        idle();

        // Memory wait: 3 unacknowledged cycles then the ack cycle.
        dmem_req = 1;
        for (int i = 0; i < 3; i++) step("memwait");
        dmem_ack = 1;
        step("memack");
        check("memwait_cnt", 64'(mc0), 64'd3);
        idle();

        // Trap with jump and hazard present; trap_req dropped after entry.
        trap_req = 1; id_jump = 1;
        ex_reg_we = 1; ex_mem_rd = 1; ex_rd = 5; id_rs1 = 5; id_rs1_type = Type1;
        step("trap_entry");
        trap_req = 0;
        step("trap_drain1");
        step("trap_drain2");
        step("trap_done");
        idle();
        step("trap_idle");

        // Reset in the middle of a memory wait.
        dmem_req = 1;
        step("rstmw_a");
        step("rstmw_b");
        reset_n = 0;
        step("rstmw_rst");
        check("rstmw_hcnt", 64'(hc0), 64'd0);
        check("rstmw_mcnt", 64'(mc0), 64'd0);
        reset_n = 1; dmem_req = 0;
        step("rstmw_release");

        // Random traffic over a small register set to force collisions.
        for (int n = 0; n < 3000; n++) begin
            reset_n     = ($urandom_range(0, 199) != 0);
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            id_rs1_type = forwarding_type_t'($urandom_range(0, 3));
            id_rs2_type = forwarding_type_t'($urandom_range(0, 3));
            ex_reg_we   = 1'($urandom_range(0, 1));
            ex_mem_rd   = 1'($urandom_range(0, 1));
            ex_rd       = 5'($urandom_range(0, 3));
            mem_reg_we  = 1'($urandom_range(0, 1));
            mem_mem_rd  = 1'($urandom_range(0, 1));
            mem_rd      = 5'($urandom_range(0, 3));
            id_jump     = ($urandom_range(0, 4) == 0);
            fetch_req   = ($urandom_range(0, 2) == 0);
            fetch_ack   = 1'($urandom_range(0, 1));
            dmem_req    = ($urandom_range(0, 4) == 0);
            dmem_ack    = 1'($urandom_range(0, 1));
            trap_req    = ($urandom_range(0, 29) == 0);
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
